// File: rtl/sd_programm_lader_if.sv
// Bundle between the boot loader, the SD card reader and the program/data RAM port.
// master = the surroundings (Start, SD reader), slave = the loader itself.
interface sd_programm_lader_if #(
    parameter int ADRESS_BREITE = 16
);
    logic                     start;
    logic [31:0]              sd_daten;
    logic                     sd_busy;
    logic [31:0]              sd_adresse;
    logic                     sd_lesen;
    logic [ADRESS_BREITE-1:0] ram_adresse;
    logic [31:0]              ram_daten;
    logic                     ram_schreiben;
    logic                     lade_aktiv;
    logic                     fertig;
    logic                     fehler;

    modport master (
        output start, sd_daten, sd_busy,
        input  sd_adresse, sd_lesen, ram_adresse, ram_daten, ram_schreiben,
               lade_aktiv, fertig, fehler
    );

    modport slave (
        input  start, sd_daten, sd_busy,
        output sd_adresse, sd_lesen, ram_adresse, ram_daten, ram_schreiben,
               lade_aktiv, fertig, fehler
    );
endinterface

// File: rtl/sd_programm_lader.sv
// Boot loader: reads word count N, then N words from SD, writes them to RAM[0..N-1].
// Define LADER_PRUEFSUMME_EN to read and verify a trailing XOR checksum word.
module sd_programm_lader #(
    parameter int          ADRESS_BREITE = 16,
    parameter int          RAM_WORTE     = 1024,
    parameter logic [31:0] BASIS_ADRESSE = 32'd0,
    parameter int          ABSTAND       = 31
) (
    input  logic               i_clk,
    input  logic               i_rst,
    sd_programm_lader_if.slave io_lader
);
    localparam int IW = ADRESS_BREITE + 1;
    localparam int CW = (ABSTAND > 0) ? $clog2(ABSTAND + 1) : 1;

    typedef enum logic [2:0] {
        LEERLAUF, ANFORDERN, WARTE_BUSY, WARTE_DATEN, SCHREIBEN, FERTIG, FEHLER
    } state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_abstand;
    logic [IW-1:0] r_index, r_anzahl;
    logic [31:0]   r_sd_adresse, r_daten;
    logic          r_kopf, r_lade_aktiv, r_fertig, r_fehler;
`ifdef LADER_PRUEFSUMME_EN
    logic          r_pruef;
    logic [31:0]   r_xor;
`endif
    logic w_sd_lesen, w_anfrage, w_letztes, w_n_null, w_n_zu_gross;

    // The reader corrupts back-to-back requests, so each request waits out the spacing count.
    assign w_anfrage    = (r_abstand == '0) && !io_lader.sd_busy;
    assign w_letztes    = (r_index + IW'(1)) == r_anzahl;
    assign w_n_null     = io_lader.sd_daten == 32'd0;
    assign w_n_zu_gross = io_lader.sd_daten > 32'(RAM_WORTE);

    always_comb begin
        w_next     = r_state;
        w_sd_lesen = 1'b0;
        case (r_state)
            LEERLAUF:   if (io_lader.start) w_next = ANFORDERN;
            ANFORDERN: begin
                if (w_anfrage) begin
                    w_sd_lesen = 1'b1;
                    w_next     = WARTE_BUSY;
                end
            end
            WARTE_BUSY: if (io_lader.sd_busy) w_next = WARTE_DATEN;
            WARTE_DATEN: begin
                if (!io_lader.sd_busy) begin
                    if (r_kopf) begin
                        if (w_n_zu_gross)
                            w_next = FEHLER;
                        else if (w_n_null)
`ifdef LADER_PRUEFSUMME_EN
                            w_next = ANFORDERN;
`else
                            w_next = FERTIG;
`endif
                        else
                            w_next = ANFORDERN;
                    end
`ifdef LADER_PRUEFSUMME_EN
                    else if (r_pruef)
                        w_next = (io_lader.sd_daten == r_xor) ? FERTIG : FEHLER;
`endif
                    else
                        w_next = SCHREIBEN;
                end
            end
`ifdef LADER_PRUEFSUMME_EN
            SCHREIBEN:  w_next = ANFORDERN;
`else
            SCHREIBEN:  w_next = w_letztes ? FERTIG : ANFORDERN;
`endif
            FERTIG:     w_next = LEERLAUF;
            FEHLER:     w_next = LEERLAUF;
            default:    w_next = LEERLAUF;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= LEERLAUF;
        else       r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_abstand    <= CW'(ABSTAND);
            r_index      <= '0;
            r_anzahl     <= '0;
            r_sd_adresse <= '0;
            r_daten      <= '0;
            r_kopf       <= 1'b0;
            r_lade_aktiv <= 1'b0;
            r_fertig     <= 1'b0;
            r_fehler     <= 1'b0;
`ifdef LADER_PRUEFSUMME_EN
            r_pruef      <= 1'b0;
            r_xor        <= '0;
`endif
        end else begin
            case (r_state)
                LEERLAUF: begin
                    if (io_lader.start) begin
                        r_fertig     <= 1'b0;
                        r_fehler     <= 1'b0;
                        r_lade_aktiv <= 1'b1;
                        r_sd_adresse <= BASIS_ADRESSE;
                        r_index      <= '0;
                        r_abstand    <= CW'(ABSTAND);
                        r_kopf       <= 1'b1;
`ifdef LADER_PRUEFSUMME_EN
                        r_pruef      <= 1'b0;
                        r_xor        <= '0;
`endif
                    end
                end
                ANFORDERN: begin
                    if (!io_lader.sd_busy)
                        r_abstand <= (r_abstand == '0) ? CW'(ABSTAND) : r_abstand - CW'(1);
                end
                WARTE_DATEN: begin
                    if (!io_lader.sd_busy) begin
                        if (r_kopf) begin
                            r_kopf   <= 1'b0;
                            r_anzahl <= io_lader.sd_daten[IW-1:0];
`ifdef LADER_PRUEFSUMME_EN
                            // With N=0 the next word is already the checksum.
                            if (!w_n_zu_gross) begin
                                r_sd_adresse <= r_sd_adresse + 32'd1;
                                r_pruef      <= w_n_null;
                            end
`else
                            if (!w_n_zu_gross && !w_n_null)
                                r_sd_adresse <= r_sd_adresse + 32'd1;
`endif
                        end
`ifdef LADER_PRUEFSUMME_EN
                        else if (!r_pruef) begin
                            r_daten <= io_lader.sd_daten;
                            r_xor   <= r_xor ^ io_lader.sd_daten;
                        end
`else
                        else
                            r_daten <= io_lader.sd_daten;
`endif
                    end
                end
                SCHREIBEN: begin
                    r_index <= r_index + IW'(1);
`ifdef LADER_PRUEFSUMME_EN
                    r_sd_adresse <= r_sd_adresse + 32'd1;
                    if (w_letztes) r_pruef <= 1'b1;
`else
                    if (!w_letztes) r_sd_adresse <= r_sd_adresse + 32'd1;
`endif
                end
                FERTIG: begin
                    r_fertig     <= 1'b1;
                    r_lade_aktiv <= 1'b0;
                end
                FEHLER: begin
                    r_fehler     <= 1'b1;
                    r_lade_aktiv <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign io_lader.sd_adresse    = r_sd_adresse;
    assign io_lader.sd_lesen      = w_sd_lesen;
    assign io_lader.ram_adresse   = r_index[ADRESS_BREITE-1:0];
    assign io_lader.ram_daten     = r_daten;
    assign io_lader.ram_schreiben = (r_state == SCHREIBEN);
    assign io_lader.lade_aktiv    = r_lade_aktiv;
    assign io_lader.fertig        = r_fertig;
    assign io_lader.fehler        = r_fehler;
endmodule

// File: tb/tb_sd_programm_lader.sv
// Bench for sd_programm_lader: SD reader model, RAM write log, spec-level expectations.
module tb_sd_programm_lader;
    localparam int AB   = 16;
    localparam int RW   = 1024;
    localparam int ABST = 31;
`ifdef LADER_PRUEFSUMME_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic init_busy = 1'b0;
    logic rd_busy   = 1'b0;
    int   rd_lat_max = 3;
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    logic [31:0] sd_mem [0:2047];

    int   n_both = 0, n_overlap = 0, n_bad_addr = 0;
    int   last_lesen = -1;
    int   min_gap    = 1000000;
    int   pre_low    = 0;
    bit   first_seen = 1'b0;
    logic [31:0] lesen_q [$];
    logic [47:0] wlog_q  [$];

    sd_programm_lader_if #(.ADRESS_BREITE(AB)) bus();
    assign bus.sd_busy = init_busy | rd_busy;

    sd_programm_lader #(
        .ADRESS_BREITE(AB), .RAM_WORTE(RW), .BASIS_ADRESSE(32'd0), .ABSTAND(ABST)
    ) dut (
        .i_clk(clk), .i_rst(rst), .io_lader(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SD reader: busy rises after a request, data appears when busy falls.
    initial begin
        logic [31:0] addr;
        int lat;
        bus.sd_daten = '0;
        forever begin
            @(negedge clk);
            if (bus.sd_lesen === 1'b1) begin
                addr = bus.sd_adresse;
                @(posedge clk);
                #1 rd_busy = 1'b1;
                lat = $urandom_range(rd_lat_max, 1);
                repeat (lat) @(posedge clk);
                #1 rd_busy = 1'b0;
                bus.sd_daten = sd_mem[addr[10:0]];
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.start && !bus.lade_aktiv) begin
                    pre_low    = 0;
                    first_seen = 1'b0;
                end
                if (bus.lade_aktiv && !bus.sd_busy && !first_seen) pre_low++;
                if (bus.sd_lesen) begin
                    first_seen = 1'b1;
                    lesen_q.push_back(bus.sd_adresse);
                    if (last_lesen >= 0 && cyc - last_lesen < min_gap) min_gap = cyc - last_lesen;
                    last_lesen = cyc;
                    if (rd_busy) n_overlap++;
                end
                if (bus.ram_schreiben) begin
                    wlog_q.push_back({bus.ram_adresse, bus.ram_daten});
                    if (int'(bus.ram_adresse) >= RW) n_bad_addr++;
                end
                if (bus.sd_lesen && bus.ram_schreiben) n_both++;
            end
        end
    end

    task automatic pulse_start;
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit to);
        to = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!bus.lade_aktiv && (bus.fertig || bus.fehler)) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    // Header word plus the XOR of the data words one address past the data.
    task automatic bild_kopf(input int n);
        logic [31:0] x;
        x = '0;
        sd_mem[0] = 32'(n);
        for (int k = 1; k <= n && k < 2047; k++) x ^= sd_mem[k];
        if (n + 1 < 2048) sd_mem[n+1] = x;
    endtask

    function automatic logic [84:0] ausgaben();
        return {bus.sd_adresse, bus.sd_lesen, bus.ram_adresse, bus.ram_daten,
                bus.ram_schreiben, bus.lade_aktiv, bus.fertig, bus.fehler};
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (ausgaben() !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %h want 0", ausgaben());
        end
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        compared++;
        if (ausgaben() !== '0) begin
            mismatched++;
            $display("FAIL idle_outputs: got %h want 0", ausgaben());
        end
    endtask

    task automatic test_drei_worte;
        int l0, w0;
        bit to;
        logic [31:0] w [3];
        w[0] = 32'hA1A1A1A1; w[1] = 32'hB2B2B2B2; w[2] = 32'hC3C3C3C3;
        for (int k = 0; k < 3; k++) sd_mem[k+1] = w[k];
        bild_kopf(3);
        l0 = lesen_q.size(); w0 = wlog_q.size();
        pulse_start();
        wait_done(2000, to);
        compared++;
        if (to) begin mismatched++; $display("FAIL n3_timeout: no completion within 2000 cycles"); end
        compared++;
        if (lesen_q.size() - l0 != 4 + CK) begin
            mismatched++; $display("FAIL n3_lesen_count: got %0d want %0d", lesen_q.size() - l0, 4 + CK);
        end
        compared++;
        if (wlog_q.size() - w0 != 3) begin
            mismatched++; $display("FAIL n3_write_count: got %0d want 3", wlog_q.size() - w0);
        end else begin
            for (int k = 0; k < 3; k++) begin
                compared++;
                if (wlog_q[w0+k] !== {16'(k), w[k]}) begin
                    mismatched++; $display("FAIL n3_ram_word%0d: got %h want %h", k, wlog_q[w0+k], {16'(k), w[k]});
                end
            end
        end
        compared++;
        if ({bus.fertig, bus.fehler, bus.lade_aktiv} !== 3'b100) begin
            mismatched++; $display("FAIL n3_flags: got %b want 100", {bus.fertig, bus.fehler, bus.lade_aktiv});
        end
        compared++;
        if (pre_low != ABST + 1) begin
            mismatched++; $display("FAIL n3_first_spacing: got %0d want %0d", pre_low, ABST + 1);
        end
    endtask

    task automatic test_null;
        int l0, w0;
        bit to;
        bild_kopf(0);
        l0 = lesen_q.size(); w0 = wlog_q.size();
        pulse_start();
        wait_done(2000, to);
        compared++;
        if (to || lesen_q.size() - l0 != 1 + CK) begin
            mismatched++; $display("FAIL n0_lesen: got %0d (timeout %0d) want %0d", lesen_q.size() - l0, to, 1 + CK);
        end
        compared++;
        if (wlog_q.size() != w0) begin
            mismatched++; $display("FAIL n0_writes: got %0d want 0", wlog_q.size() - w0);
        end
        compared++;
        if ({bus.fertig, bus.fehler} !== 2'b10) begin
            mismatched++; $display("FAIL n0_flags: got %b want 10", {bus.fertig, bus.fehler});
        end
    endtask

    task automatic test_zu_gross;
        int l0, w0;
        bit to;
        bild_kopf(RW + 1);
        l0 = lesen_q.size(); w0 = wlog_q.size();
        pulse_start();
        wait_done(2000, to);
        compared++;
        if (to || lesen_q.size() - l0 != 1) begin
            mismatched++; $display("FAIL big_lesen: got %0d (timeout %0d) want 1", lesen_q.size() - l0, to);
        end
        compared++;
        if (wlog_q.size() != w0) begin
            mismatched++; $display("FAIL big_writes: got %0d want 0", wlog_q.size() - w0);
        end
        compared++;
        if ({bus.fertig, bus.fehler, bus.lade_aktiv} !== 3'b010) begin
            mismatched++; $display("FAIL big_flags: got %b want 010", {bus.fertig, bus.fehler, bus.lade_aktiv});
        end
    endtask

    // Random images; a second Start in mid-load must be ignored.
    task automatic test_random;
        int l0, w0, n, err_a, err_w;
        bit to;
        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(12, 2);
            rd_lat_max = $urandom_range(4, 1);
            for (int k = 1; k <= n; k++) sd_mem[k] = $urandom;
            bild_kopf(n);
            l0 = lesen_q.size(); w0 = wlog_q.size();
            pulse_start();
            repeat (40 + $urandom_range(20)) @(posedge clk);
            #1 bus.start = 1'b1;
            @(posedge clk);
            #1 bus.start = 1'b0;
            wait_done(60 * (n + 2), to);
            compared++;
            if (to || lesen_q.size() - l0 != n + 1 + CK) begin
                mismatched++; $display("FAIL rnd%0d_lesen: got %0d (timeout %0d) want %0d", r, lesen_q.size() - l0, to, n + 1 + CK);
            end else begin
                err_a = 0;
                for (int k = 0; k <= n + CK; k++) if (lesen_q[l0+k] !== 32'(k)) err_a++;
                compared++;
                if (err_a != 0) begin
                    mismatched++; $display("FAIL rnd%0d_sd_addr: %0d wrong addresses want 0", r, err_a);
                end
            end
            compared++;
            if (wlog_q.size() - w0 != n) begin
                mismatched++; $display("FAIL rnd%0d_writes: got %0d want %0d", r, wlog_q.size() - w0, n);
            end else begin
                err_w = 0;
                for (int k = 0; k < n; k++) if (wlog_q[w0+k] !== {16'(k), sd_mem[k+1]}) err_w++;
                compared++;
                if (err_w != 0) begin
                    mismatched++; $display("FAIL rnd%0d_ram: %0d wrong words want 0", r, err_w);
                end
            end
            compared++;
            if ({bus.fertig, bus.fehler} !== 2'b10) begin
                mismatched++; $display("FAIL rnd%0d_flags: got %b want 10", r, {bus.fertig, bus.fehler});
            end
        end
        rd_lat_max = 3;
    endtask

    task automatic test_init_busy;
        int l0;
        bit to;
        init_busy = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 1; k <= 2; k++) sd_mem[k] = $urandom;
        bild_kopf(2);
        repeat (200) @(posedge clk);
        l0 = lesen_q.size();
        pulse_start();
        repeat (300) @(posedge clk);
        compared++;
        if (lesen_q.size() != l0) begin
            mismatched++; $display("FAIL busy_request_while_init: got %0d want 0", lesen_q.size() - l0);
        end
        #1 init_busy = 1'b0;
        repeat (10) @(posedge clk);
        #1 init_busy = 1'b1;
        repeat (7) @(posedge clk);
        #1 init_busy = 1'b0;
        wait_done(2000, to);
        compared++;
        if (to || pre_low != ABST + 1) begin
            mismatched++; $display("FAIL busy_first_spacing: got %0d idle cycles (timeout %0d) want %0d", pre_low, to, ABST + 1);
        end
        compared++;
        if ({bus.fertig, bus.fehler} !== 2'b10) begin
            mismatched++; $display("FAIL busy_flags: got %b want 10", {bus.fertig, bus.fehler});
        end
    endtask

    task automatic test_reset_mitten;
        int l0, w0;
        bit to, hit;
        for (int k = 1; k <= 3; k++) sd_mem[k] = $urandom;
        bild_kopf(3);
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            if (bus.ram_schreiben && bus.ram_adresse == 16'd1) hit = 1'b1;
        end
        compared++;
        if (!hit) begin
            mismatched++; $display("FAIL midreset_reach_word1: got no write of word 1 want one");
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        compared++;
        if (ausgaben() !== '0) begin
            mismatched++; $display("FAIL midreset_outputs: got %h want 0", ausgaben());
        end
        rst = 1'b0;
        l0 = lesen_q.size(); w0 = wlog_q.size();
        pulse_start();
        wait_done(2000, to);
        compared++;
        if (to || lesen_q.size() - l0 != 4 + CK || lesen_q[l0] !== 32'd0) begin
            mismatched++; $display("FAIL midreset_reload: got %0d requests (timeout %0d) want %0d from address 0", lesen_q.size() - l0, to, 4 + CK);
        end
        compared++;
        if (wlog_q.size() - w0 != 3 || wlog_q[w0+2] !== {16'd2, sd_mem[3]}) begin
            mismatched++; $display("FAIL midreset_writes: got %0d writes want 3 ending %h", wlog_q.size() - w0, {16'd2, sd_mem[3]});
        end
    endtask

    // N equal to the RAM size must load completely without the index wrapping.
    task automatic test_voll;
        int w0, err_w;
        bit to;
        rd_lat_max = 1;
        for (int k = 1; k <= RW; k++) sd_mem[k] = $urandom;
        bild_kopf(RW);
        w0 = wlog_q.size();
        pulse_start();
        wait_done(45 * (RW + 2), to);
        compared++;
        if (to || wlog_q.size() - w0 != RW) begin
            mismatched++; $display("FAIL full_writes: got %0d (timeout %0d) want %0d", wlog_q.size() - w0, to, RW);
        end else begin
            err_w = 0;
            for (int k = 0; k < RW; k++) if (wlog_q[w0+k] !== {16'(k), sd_mem[k+1]}) err_w++;
            compared++;
            if (err_w != 0) begin
                mismatched++; $display("FAIL full_ram: %0d wrong words want 0", err_w);
            end
        end
        compared++;
        if ({bus.fertig, bus.fehler} !== 2'b10) begin
            mismatched++; $display("FAIL full_flags: got %b want 10", {bus.fertig, bus.fehler});
        end
        rd_lat_max = 3;
    endtask

`ifdef LADER_PRUEFSUMME_EN
    task automatic test_pruefsumme;
        int w0;
        bit to;
        sd_mem[0] = 32'd2;
        sd_mem[1] = 32'h0000FFFF;
        sd_mem[2] = 32'hFFFF0000;
        for (int r = 0; r < 2; r++) begin
            sd_mem[3] = (r == 0) ? 32'hFFFFFFFF : 32'hFFFFFFFE;
            w0 = wlog_q.size();
            pulse_start();
            wait_done(2000, to);
            compared++;
            if (to || {bus.fertig, bus.fehler} !== ((r == 0) ? 2'b10 : 2'b01)) begin
                mismatched++; $display("FAIL cks%0d_flags: got %b (timeout %0d) want %b", r, {bus.fertig, bus.fehler}, to, (r == 0) ? 2'b10 : 2'b01);
            end
            compared++;
            if (wlog_q.size() - w0 != 2) begin
                mismatched++; $display("FAIL cks%0d_writes: got %0d want 2", r, wlog_q.size() - w0);
            end
        end
    endtask
`endif

    task automatic test_protokoll;
        compared++;
        if (n_both != 0) begin
            mismatched++; $display("FAIL read_and_write_same_cycle: got %0d want 0", n_both);
        end
        compared++;
        if (n_overlap != 0) begin
            mismatched++; $display("FAIL outstanding_requests: got %0d overlaps want 0", n_overlap);
        end
        compared++;
        if (n_bad_addr != 0) begin
            mismatched++; $display("FAIL ram_addr_range: got %0d bad writes want 0", n_bad_addr);
        end
        compared++;
        if (min_gap < ABST + 1) begin
            mismatched++; $display("FAIL request_gap: got %0d cycles want >= %0d", min_gap, ABST + 1);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        for (int k = 0; k < 2048; k++) sd_mem[k] = '0;
        test_reset();
        test_drei_worte();
        test_null();
        test_zu_gross();
        test_random();
        test_init_busy();
        test_reset_mitten();
        test_voll();
`ifdef LADER_PRUEFSUMME_EN
        test_pruefsumme();
`endif
        test_protokoll();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
